// File: rtl/dpram_rd_streamer.sv
// Read-side streamer for dpram: issues a wrapping run of reads and presents the
// returned words as a valid/ready stream, hiding the one-cycle read latency.
module dpram_rd_streamer #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   length,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] rdaddr,
   input  logic [DATA_WIDTH-1:0] rddata,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

   localparam logic [ADDR_WIDTH:0] LEN_ONE  = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH:0] LEN_ZERO = '0;

   state_t                state_reg;
   logic [ADDR_WIDTH-1:0] rdaddr_reg;
   logic [ADDR_WIDTH:0]   remaining_reg;
   logic                  pend_reg;
   logic                  pend_last_reg;
   logic [DATA_WIDTH-1:0] fifo_data [2];
   logic                  fifo_last [2];
   logic                  wr_ptr_reg;
   logic                  rd_ptr_reg;
   logic [1:0]            count_reg;

   logic                  push;
   logic                  pop;
   logic                  issue;
   logic [1:0]            credit_use;

   assign push = pend_reg;
   assign pop  = m_valid & m_ready;

   // Occupancy is taken after this cycle's pop so a steady stream keeps one
   // read in flight and one word buffered, sustaining a beat per clock.
   assign credit_use = count_reg + 2'(pend_reg) - 2'(pop);
   assign issue      = (state_reg == ISSUE) && (credit_use < 2'd2);

   assign busy    = (state_reg != IDLE);
   assign done    = (state_reg == FINISH);
   assign rdaddr  = rdaddr_reg;
   assign m_valid = (count_reg != 2'd0);
   assign m_data  = fifo_data[rd_ptr_reg];
   assign m_last  = m_valid & fifo_last[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         rdaddr_reg    <= '0;
         remaining_reg <= '0;
         pend_reg      <= 1'b0;
         pend_last_reg <= 1'b0;
         fifo_data[0]  <= '0;
         fifo_data[1]  <= '0;
         fifo_last[0]  <= 1'b0;
         fifo_last[1]  <= 1'b0;
         wr_ptr_reg    <= 1'b0;
         rd_ptr_reg    <= 1'b0;
         count_reg     <= 2'd0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  rdaddr_reg    <= base_addr;
                  remaining_reg <= length;
                  state_reg     <= (length == LEN_ZERO) ? FINISH : ISSUE;
               end
            end
            ISSUE: begin
               if (issue) begin
                  rdaddr_reg    <= rdaddr_reg + 1'b1;
                  remaining_reg <= remaining_reg - LEN_ONE;
                  if (remaining_reg == LEN_ONE) state_reg <= DRAIN;
               end
            end
            DRAIN: begin
               if (pop && m_last) state_reg <= FINISH;
            end
            FINISH:  state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase

         // The last flag travels with its read so m_last is tied to the word.
         pend_reg      <= issue;
         pend_last_reg <= issue && (remaining_reg == LEN_ONE);

         if (push) begin
            fifo_data[wr_ptr_reg] <= rddata;
            fifo_last[wr_ptr_reg] <= pend_last_reg;
            wr_ptr_reg            <= ~wr_ptr_reg;
         end
         if (pop) rd_ptr_reg <= ~rd_ptr_reg;
         count_reg <= count_reg + 2'(push) - 2'(pop);
      end
   end

endmodule

// File: tb/tb_dpram_rd_streamer.sv
// Bench for dpram_rd_streamer: a behavioural dpram read port feeds the DUT and a
// scoreboard queue of expected {last,data} beats is checked at every handshake.
module tb_dpram_rd_streamer;

   localparam int AW = 4;
   localparam int DW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          m_ready = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   length = '0;
   logic          busy, done, m_valid, m_last;
   logic [AW-1:0] rdaddr;
   logic [DW-1:0] rddata;
   logic [DW-1:0] m_data;

   logic [DW-1:0] ram [16];
   logic [DW:0]   exp_q [$];
   logic [DW:0]   mon_e;

   int pass_cnt = 0;
   int total_cnt = 0;
   int cyc = 0;
   bit mon_en = 1'b0;
   int beat_cnt = 0;
   int done_cnt = 0;
   int first_valid_cyc = -1;
   int last_cyc = -1;
   int done_cyc = -1;
   logic          stall_prev = 1'b0;
   logic [DW-1:0] stall_data = '0;
   logic          stall_last = 1'b0;

   dpram_rd_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .length(length), .busy(busy), .done(done), .rdaddr(rdaddr),
      .rddata(rddata), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data), .m_last(m_last)
   );

   always #5 clk = ~clk;

   // dpram read port: registered read of the address sampled on this edge.
   always @(posedge clk) begin
      cyc++;
      rddata <= ram[rdaddr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (stall_prev) begin
            check("stall_valid", 32'(m_valid), 32'd1);
            check("stall_data", 32'(m_data), 32'(stall_data));
            check("stall_last", 32'(m_last), 32'(stall_last));
         end
         if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (m_valid && m_ready) begin
            beat_cnt++;
            if (exp_q.size() == 0) begin
               check("extra_beat", 32'd1, 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check("beat_data", 32'(m_data), 32'(mon_e[DW-1:0]));
               check("beat_last", 32'(m_last), 32'(mon_e[DW]));
               $display("beat %0d data=%0h last=%0b cyc=%0d", beat_cnt, m_data, m_last, cyc);
            end
            if (m_last) last_cyc = cyc;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         stall_prev = m_valid && !m_ready;
         stall_data = m_data;
         stall_last = m_last;
      end
   end

   task automatic run(input int base, input int len, input bit rnd, input bit mid);
      int  sc;
      bit  seen;
      for (int i = 0; i < len; i++)
         exp_q.push_back({1'(i == len - 1), ram[4'(base + i)]});
      beat_cnt = 0; done_cnt = 0; first_valid_cyc = -1; last_cyc = -1; done_cyc = -1;
      @(posedge clk); #1;
      base_addr = base[AW-1:0];
      length = len[AW:0];
      start = 1'b1;
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      sc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 300 && !seen; k++) begin
         if (mid && k == 3) begin
            base_addr = 4'd9;
            length = 5'd3;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (rnd) m_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (k == 0) check("busy_after_start", 32'(busy), 32'd1);
         if (done) seen = 1'b1;
         @(posedge clk); #1;
      end
      start = 1'b0;
      check("done_seen", 32'(seen), 32'd1);
      @(negedge clk); #1;
      check("busy_after_done", 32'(busy), 32'd0);
      check("done_single", 32'(done_cnt), 32'd1);
      check("beat_count", 32'(beat_cnt), 32'(len));
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      if (len == 0) begin
         check("len0_no_valid", 32'(first_valid_cyc), 32'hFFFF_FFFF);
         check("len0_done_cyc", 32'(done_cyc), 32'(sc + 1));
      end else begin
         check("done_after_last", 32'(done_cyc), 32'(last_cyc + 1));
         if (!rnd) begin
            check("first_valid_latency", 32'(first_valid_cyc), 32'(sc + 3));
            check("last_beat_cyc", 32'(last_cyc), 32'(sc + 3 + len - 1));
         end
      end
      $display("cmd base=%0d len=%0d rnd=%0b mid=%0b beats=%0d done_cnt=%0d", base, len, rnd, mid, beat_cnt, done_cnt);
   endtask

   initial begin
      int guard;
      for (int i = 0; i < 16; i++) ram[i] = 4'(i);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_last", 32'(m_last), 32'd0);
      check("rst_m_data", 32'(m_data), 32'd0);
      check("rst_rdaddr", 32'(rdaddr), 32'd0);
      rst_n = 1'b1;
      mon_en = 1'b1;

      run(0, 8, 1'b0, 1'b0);
      run(6, 4, 1'b0, 1'b0);
      run(14, 4, 1'b0, 1'b0);
      check("rdaddr_wrap_hold", 32'(rdaddr), 32'd2);
      run(0, 16, 1'b1, 1'b0);
      run(5, 16, 1'b1, 1'b0);
      run(0, 0, 1'b0, 1'b0);
      run(3, 8, 1'b0, 1'b1);

      // Abort an 8-word read after three beats.
      for (int i = 0; i < 8; i++) exp_q.push_back({1'(i == 7), ram[i]});
      beat_cnt = 0; done_cnt = 0;
      @(posedge clk); #1;
      base_addr = '0; length = 5'd8; start = 1'b1; m_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      guard = 0;
      while (beat_cnt < 3 && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      check("abort_reach_3_beats", 32'(beat_cnt), 32'd3);
      rst_n = 1'b0;
      mon_en = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_q.delete();
      stall_prev = 1'b0;
      @(negedge clk);
      check("abort_m_valid", 32'(m_valid), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      beat_cnt = 0; done_cnt = 0;
      mon_en = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check("abort_no_done", 32'(done_cnt), 32'd0);
      check("abort_no_beats", 32'(beat_cnt), 32'd0);
      $display("abort after 3 beats: done_cnt=%0d beats_after=%0d", done_cnt, beat_cnt);

      run(0, 2, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
